// File: rtl/mem_initiator.sv
// Request-side master for the single-port memory valid/ready interface.
// Runs one command at a time through the memory handshake and returns one response, with an optional timeout.
module mem_initiator #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TIMEOUT    = 15,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [WIDTH-1:0]      cmd_wdata_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [7:0]            err_cnt_o
);

    localparam int unsigned CNT_W   = 16;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2,
        RSP    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]      wait_q, wait_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        wait_d      = wait_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    wr_d    = cmd_wr_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wr_i ? cmd_wdata_i : '0;
                    valid_d = 1'b1;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A handshake on the timeout edge wins over the abort
                if (ready_i) begin
                    valid_d = 1'b0;
                    wait_d  = '0;
                    if (wr_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                        state_d     = RSP;
                    end else begin
                        state_d = RDWAIT;
                    end
                end else if (TO_EN && (wait_q == CNT_W'(TO_LAST))) begin
                    valid_d     = 1'b0;
                    wait_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = RSP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            RDWAIT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = rdata_i;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            wait_q      <= wait_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign valid_o     = valid_q;
    assign wr_rd_o     = wr_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: vector table plus timeout, backpressure and reset sequences.
module tb_mem_initiator;

    logic        clk;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [3:0]  cmd_addr_i;
    logic [15:0] cmd_wdata_i;
    logic        valid_o;
    logic        wr_rd_o;
    logic [3:0]  addr_o;
    logic [15:0] wdata_o;
    logic        ready_i;
    logic [15:0] rdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [7:0]  err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int rsp_cnt  = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_bus_wdata;
        int          low;
        logic [15:0] mem;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    mem_initiator #(.DEPTH(16), .WIDTH(16), .TIMEOUT(15)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_wr_i    (cmd_wr_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .valid_o     (valid_o),
        .wr_rd_o     (wr_rd_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .ready_i     (ready_i),
        .rdata_i     (rdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory handshakes and consumed responses
    always @(posedge clk) begin
        if (valid_o && ready_i)         hs_cnt  <= hs_cnt + 1;
        if (rsp_valid_o && rsp_ready_i) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again
    task automatic run_vec(input vec_t v, input string tag);
        int hs0;
        int rsp0;
        hs0  = hs_cnt;
        rsp0 = rsp_cnt;
        check({tag, " cmd_ready idle"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = v.wr;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        ready_i     = (v.low == 0);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check({tag, " valid after accept"}, 32'(valid_o), 32'd1);
        check({tag, " wr_rd"}, 32'(wr_rd_o), 32'(v.wr));
        check({tag, " addr"}, 32'(addr_o), 32'(v.addr));
        check({tag, " wdata"}, 32'(wdata_o), 32'(v.exp_bus_wdata));
        check({tag, " cmd_ready busy"}, 32'(cmd_ready_o), 32'd0);
        for (int i = 0; i < v.low; i++) begin
            ready_i = 1'b0;
            @(negedge clk);
            check({tag, " stall valid"}, 32'(valid_o), 32'd1);
            check({tag, " stall addr"}, 32'(addr_o), 32'(v.addr));
            check({tag, " stall wdata"}, 32'(wdata_o), 32'(v.exp_bus_wdata));
            check({tag, " stall wr_rd"}, 32'(wr_rd_o), 32'(v.wr));
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, " valid after hs"}, 32'(valid_o), 32'd0);
        if (v.wr) begin
            check({tag, " wr rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        end else begin
            check({tag, " rd no early rsp"}, 32'(rsp_valid_o), 32'd0);
            rdata_i = v.mem;
            @(negedge clk);
            rdata_i = 16'hDEAD;
            check({tag, " rd rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        end
        check({tag, " rsp_rdata"}, 32'(rsp_rdata_o), 32'(v.exp_rdata));
        check({tag, " rsp_err"}, 32'(rsp_err_o), 32'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check({tag, " rsp consumed"}, 32'(rsp_valid_o), 32'd0);
        check({tag, " back to idle"}, 32'(cmd_ready_o), 32'd1);
        check({tag, " one handshake"}, 32'(hs_cnt - hs0), 32'd1);
        check({tag, " one response"}, 32'(rsp_cnt - rsp0), 32'd1);
    endtask

    initial begin
        int   hs0;
        int   rsp0;
        vec_t v;

        vecs[0] = '{1'b1, 4'd3,  16'hABCD, 16'hABCD, 0,  16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 4'd3,  16'h1111, 16'h0000, 0,  16'hABCD, 16'hABCD};
        vecs[2] = '{1'b1, 4'd15, 16'hFFFF, 16'hFFFF, 0,  16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 4'd0,  16'h7777, 16'h0000, 2,  16'h1234, 16'h1234};
        vecs[4] = '{1'b1, 4'd7,  16'h5A5A, 16'h5A5A, 4,  16'h0000, 16'h0000};
        vecs[5] = '{1'b0, 4'd15, 16'h0F0F, 16'h0000, 14, 16'hFFFF, 16'hFFFF};

        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 4'd0;
        cmd_wdata_i = 16'd0;
        ready_i     = 1'b0;
        rdata_i     = 16'd0;
        rsp_ready_i = 1'b0;

        repeat (2) @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset wr_rd", 32'(wr_rd_o), 32'd0);
        check("reset addr", 32'(addr_o), 32'd0);
        check("reset wdata", 32'(wdata_o), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata_o), 32'd0);
        check("reset rsp_err", 32'(rsp_err_o), 32'd0);
        check("reset err_cnt", 32'(err_cnt_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Timeout: ready stuck low, abort on the 15th low edge
        hs0 = hs_cnt;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 4'd5;
        ready_i     = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("to valid start", 32'(valid_o), 32'd1);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            check($sformatf("to hold %0d", i), 32'(valid_o), 32'd1);
        end
        @(negedge clk);
        check("to valid dropped", 32'(valid_o), 32'd0);
        check("to rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("to rsp_err", 32'(rsp_err_o), 32'd1);
        check("to rsp_rdata", 32'(rsp_rdata_o), 32'd0);
        check("to err_cnt", 32'(err_cnt_o), 32'd1);
        check("to no handshake", 32'(hs_cnt - hs0), 32'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("to rsp consumed", 32'(rsp_valid_o), 32'd0);
        run_vec(vecs[1], "after_to");
        check("after_to err_cnt", 32'(err_cnt_o), 32'd1);

        // Response backpressure with a second command waiting
        hs0  = hs_cnt;
        rsp0 = rsp_cnt;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b1;
        cmd_addr_i  = 4'd9;
        cmd_wdata_i = 16'h1357;
        ready_i     = 1'b1;
        @(negedge clk);
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 4'd2;
        cmd_wdata_i = 16'h9999;
        check("bp first addr", 32'(addr_o), 32'd9);
        @(negedge clk);
        ready_i = 1'b0;
        check("bp rsp_valid", 32'(rsp_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp rsp held", 32'(rsp_valid_o), 32'd1);
            check("bp rsp_err held", 32'(rsp_err_o), 32'd0);
            check("bp rsp_rdata held", 32'(rsp_rdata_o), 32'd0);
            check("bp cmd_ready low", 32'(cmd_ready_o), 32'd0);
            check("bp no request", 32'(valid_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        ready_i     = 1'b1;
        check("bp rsp gone", 32'(rsp_valid_o), 32'd0);
        check("bp cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("bp not yet issued", 32'(valid_o), 32'd0);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("bp second valid", 32'(valid_o), 32'd1);
        check("bp second addr", 32'(addr_o), 32'd2);
        check("bp second wr_rd", 32'(wr_rd_o), 32'd0);
        check("bp second wdata", 32'(wdata_o), 32'd0);
        @(negedge clk);
        ready_i = 1'b0;
        rdata_i = 16'h2468;
        @(negedge clk);
        check("bp second rdata", 32'(rsp_rdata_o), 32'h2468);
        check("bp second rsp_valid", 32'(rsp_valid_o), 32'd1);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("bp handshakes", 32'(hs_cnt - hs0), 32'd2);
        check("bp responses", 32'(rsp_cnt - rsp0), 32'd2);

        // Reset pulse while a request is stalled in REQ
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b1;
        cmd_addr_i  = 4'd4;
        cmd_wdata_i = 16'hBEEF;
        ready_i     = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst pre valid", 32'(valid_o), 32'd1);
        rsp0 = rsp_cnt;
        rst_ni = 1'b0;
        #1;
        check("rst valid async", 32'(valid_o), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst err_cnt", 32'(err_cnt_o), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst addr", 32'(addr_o), 32'd0);
        check("rst wdata", 32'(wdata_o), 32'd0);
        @(negedge clk);
        rst_ni      = 1'b1;
        ready_i     = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst no response", 32'(rsp_valid_o), 32'd0);
            check("rst no request", 32'(valid_o), 32'd0);
        end
        check("rst response count", 32'(rsp_cnt - rsp0), 32'd0);
        ready_i     = 1'b0;
        rsp_ready_i = 1'b0;
        v = vecs[0];
        run_vec(v, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
